// File: rtl/btb_predictor_pkg.sv
// Shared encodings and constants for the branch target buffer.
package btb_predictor_pkg;

    // Resolved control-flow class, same encoding the control unit uses.
    localparam logic [1:0] UPD_NONE = 2'd0;
    localparam logic [1:0] UPD_J    = 2'd1;
    localparam logic [1:0] UPD_JR   = 2'd2;
    localparam logic [1:0] UPD_BR   = 2'd3;

    localparam int WORD_SIZE_DEF = 16;

    // Saturated (strongly taken) counter value.
    function automatic int unsigned cnt_max(input int bits);
        return (32'd1 << bits) - 32'd1;
    endfunction

    // Weakly taken: only the MSB set.
    function automatic int unsigned cnt_weak_taken(input int bits);
        return 32'd1 << (bits - 1);
    endfunction

endpackage

// File: rtl/btb_predictor_sat_counter.sv
// Combinational next-value for a saturating up/down counter.
module sat_counter #(
    parameter int WIDTH = 2
) (
    input  logic [WIDTH-1:0] value,
    input  logic             inc,
    input  logic             dec,
    output logic [WIDTH-1:0] next
);

    // Step toward the requested direction unless already at the rail.
    always_comb begin
        next = value;
        if (inc && !dec && (value != {WIDTH{1'b1}}))
            next = value + WIDTH'(1);
        else if (dec && !inc && (value != '0))
            next = value - WIDTH'(1);
    end

endmodule

// File: rtl/btb_predictor.sv
// Direct-mapped branch target buffer with per-entry direction counters
// and a saturating mispredict statistic. Lookup is zero-latency from the
// registered table; training happens on the rising edge.
module btb_predictor
    import btb_predictor_pkg::*;
#(
    parameter int WORD_SIZE    = WORD_SIZE_DEF,
    parameter int INDEX_BITS   = 4,
    parameter int COUNTER_BITS = 2,
    parameter int STAT_BITS    = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [WORD_SIZE-1:0]  lookup_pc,
    output logic                  pred_hit,
    output logic                  pred_taken,
    output logic [WORD_SIZE-1:0]  pred_target,
    input  logic [1:0]            update_kind,
    input  logic [WORD_SIZE-1:0]  update_pc,
    input  logic                  update_taken,
    input  logic [WORD_SIZE-1:0]  update_target,
    input  logic                  update_mispredict,
    output logic [STAT_BITS-1:0]  mispredict_count
);

    localparam int ENTRIES = 1 << INDEX_BITS;
    localparam int TAG_W   = WORD_SIZE - INDEX_BITS;
    localparam logic [COUNTER_BITS-1:0] CNT_MAX        = COUNTER_BITS'(cnt_max(COUNTER_BITS));
    localparam logic [COUNTER_BITS-1:0] CNT_WEAK_TAKEN = COUNTER_BITS'(cnt_weak_taken(COUNTER_BITS));

    logic                    valid   [ENTRIES];
    logic                    uncond  [ENTRIES];
    logic [TAG_W-1:0]        tags    [ENTRIES];
    logic [WORD_SIZE-1:0]    targets [ENTRIES];
    logic [COUNTER_BITS-1:0] counters[ENTRIES];

    logic [INDEX_BITS-1:0]   l_idx, u_idx;
    logic [TAG_W-1:0]        l_tag, u_tag;
    logic                    u_hit, u_is_jump, u_eff_taken, u_active;
    logic [COUNTER_BITS-1:0] cnt_next;
    logic [STAT_BITS-1:0]    stat_next;

    assign l_idx = lookup_pc[INDEX_BITS-1:0];
    assign l_tag = lookup_pc[WORD_SIZE-1:INDEX_BITS];
    assign u_idx = update_pc[INDEX_BITS-1:0];
    assign u_tag = update_pc[WORD_SIZE-1:INDEX_BITS];

    // Lookup path: reads the registered table, so same-cycle updates are not seen.
    always_comb begin
        pred_hit    = valid[l_idx] && (tags[l_idx] == l_tag);
        pred_taken  = pred_hit && (uncond[l_idx] || counters[l_idx][COUNTER_BITS-1]);
        pred_target = pred_taken ? targets[l_idx] : lookup_pc + WORD_SIZE'(1);
    end

    // Update decode: jumps always count as taken.
    always_comb begin
        u_active    = (update_kind != UPD_NONE);
        u_is_jump   = (update_kind == UPD_J) || (update_kind == UPD_JR);
        u_eff_taken = u_is_jump || update_taken;
        u_hit       = valid[u_idx] && (tags[u_idx] == u_tag);
    end

    sat_counter #(.WIDTH(COUNTER_BITS)) u_dir_cnt (
        .value (counters[u_idx]),
        .inc   (update_taken),
        .dec   (!update_taken),
        .next  (cnt_next)
    );

    sat_counter #(.WIDTH(STAT_BITS)) u_stat_cnt (
        .value (mispredict_count),
        .inc   (1'b1),
        .dec   (1'b0),
        .next  (stat_next)
    );

    // Table training; a not-taken miss leaves any aliasing entry alone.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid[i]    <= 1'b0;
                uncond[i]   <= 1'b0;
                tags[i]     <= '0;
                targets[i]  <= '0;
                counters[i] <= '0;
            end
        end else if (u_active) begin
            if (u_hit) begin
                if (u_is_jump) begin
                    uncond[u_idx]   <= 1'b1;
                    targets[u_idx]  <= update_target;
                    counters[u_idx] <= CNT_MAX;
                end else begin
                    uncond[u_idx]   <= 1'b0;
                    counters[u_idx] <= cnt_next;
                    if (update_taken)
                        targets[u_idx] <= update_target;
                end
            end else if (u_eff_taken) begin
                valid[u_idx]    <= 1'b1;
                tags[u_idx]     <= u_tag;
                targets[u_idx]  <= update_target;
                uncond[u_idx]   <= u_is_jump;
                counters[u_idx] <= u_is_jump ? CNT_MAX : CNT_WEAK_TAKEN;
            end
        end
    end

    // Mispredict statistic, held at all-ones by the saturating counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            mispredict_count <= '0;
        else if (u_active && update_mispredict)
            mispredict_count <= stat_next;
    end

endmodule
